// File: rtl/la_result_fifo.sv
// la_result_fifo: LA-opcode popped result FIFO; RESULT_FIFO_TIMESTAMP_EN adds per-entry cycle stamps
module la_result_fifo #(
    parameter int BITS  = 16,
    parameter int DEPTH = 4
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   res_valid,
    input  logic [BITS-1:0]        res_data,
    input  logic [15:0]            cmd,
    output logic [BITS-1:0]        rd_data,
    output logic [15:0]            rd_stamp,
    output logic                   rd_valid,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow,
    output logic                   underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [15:0] OP_POP = 16'hAC00;
    localparam logic [15:0] OP_CLR = 16'hAC01;
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    logic [BITS-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [15:0] cmd_q;
    logic pop_ev, clr, pop, push;
    always_comb begin
        pop_ev = cmd == OP_POP && cmd_q != OP_POP;
        clr = cmd == OP_CLR;
        pop = pop_ev && !empty;
        push = res_valid && (!full || pop_ev);
    end
    assign full = level == FULL_LVL;
    assign empty = level == '0;
    always_ff @(posedge wb_clk_i)
        if (wb_rst_i) begin
            cmd_q <= '0;
            wp <= '0;
            rp <= '0;
            level <= '0;
            rd_data <= '0;
            rd_valid <= 1'b0;
            overflow <= 1'b0;
            underflow <= 1'b0;
        end else begin
            cmd_q <= cmd;
            if (clr) begin
                wp <= '0;
                rp <= '0;
                level <= '0;
                rd_data <= '0;
                rd_valid <= 1'b0;
                overflow <= 1'b0;
                underflow <= 1'b0;
            end else begin
                if (push) begin
                    mem[wp] <= res_data;
                    wp <= wp + AW'(1);
                end
                if (res_valid && !push)
                    overflow <= 1'b1;
                if (pop_ev) begin
                    rd_data <= pop ? mem[rp] : '0;
                    rd_valid <= pop;
                    underflow <= underflow | !pop;
                end
                if (pop)
                    rp <= rp + AW'(1);
                level <= level + (AW+1)'(push) - (AW+1)'(pop);
            end
        end
`ifdef RESULT_FIFO_TIMESTAMP_EN
    logic [15:0] ts;
    logic [15:0] stamp_mem [DEPTH];
    always_ff @(posedge wb_clk_i)
        if (wb_rst_i) begin
            ts <= '0;
            rd_stamp <= '0;
        end else begin
            ts <= ts + 16'd1;
            if (push && !clr)
                stamp_mem[wp] <= ts;
            rd_stamp <= clr ? '0 : !pop_ev ? rd_stamp : pop ? stamp_mem[rp] : '0;
        end
`else
    assign rd_stamp = '0;
`endif
endmodule

// File: tb/tb_la_result_fifo.sv
// tb_la_result_fifo: table vectors, hand sequences and a queue scoreboard for la_result_fifo
module tb_la_result_fifo;
    localparam int DEPTH = 4;
    localparam logic [15:0] POP = 16'hAC00;
    localparam logic [15:0] CLR = 16'hAC01;
`ifdef RESULT_FIFO_TIMESTAMP_EN
    localparam bit TS = 1'b1;
`else
    localparam bit TS = 1'b0;
`endif
    typedef struct {
        logic        v;
        logic [15:0] d;
        logic [15:0] c;
        int          lvl;
        logic [15:0] rd;
        logic        rv;
        logic        ov;
        logic        un;
    } vec_t;
    logic clk = 1'b0, rst = 1'b1, res_valid = 1'b0;
    logic [15:0] res_data = '0, cmd = '0;
    logic [15:0] rd_data, rd_stamp;
    logic [2:0] level;
    logic rd_valid, full, empty, overflow, underflow;
    int checks = 0, errors = 0, cyc = 0;
    vec_t tbl[$];
    la_result_fifo #(.BITS(16), .DEPTH(DEPTH)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .res_valid(res_valid), .res_data(res_data), .cmd(cmd),
        .rd_data(rd_data), .rd_stamp(rd_stamp), .rd_valid(rd_valid), .level(level),
        .full(full), .empty(empty), .overflow(overflow), .underflow(underflow)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic step(logic v, logic [15:0] d, logic [15:0] c);
        res_valid = v;
        res_data = d;
        cmd = c;
        @(posedge clk);
        #1;
    endtask
    task automatic chk_state(string tag, int lvl, logic [15:0] rd, logic rv, logic ov, logic un);
        chk({tag, ".level"}, level, lvl);
        chk({tag, ".full"}, full, lvl == DEPTH);
        chk({tag, ".empty"}, empty, lvl == 0);
        chk({tag, ".rd_data"}, rd_data, rd);
        chk({tag, ".rd_valid"}, rd_valid, rv);
        chk({tag, ".overflow"}, overflow, ov);
        chk({tag, ".underflow"}, underflow, un);
    endtask
    function automatic void add(logic v, logic [15:0] d, logic [15:0] c, int lvl, logic [15:0] rd, logic rv, logic ov, logic un);
        tbl.push_back('{v, d, c, lvl, rd, rv, ov, un});
    endfunction
    task automatic run_tbl(string tag);
        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].d, tbl[i].c);
            chk_state($sformatf("%s[%0d]", tag, i), tbl[i].lvl, tbl[i].rd, tbl[i].rv, tbl[i].ov, tbl[i].un);
        end
        tbl.delete();
    endtask
    initial begin
        logic [15:0] qd[$], qs[$];
        logic [15:0] pcmd, erd, est, d, c;
        logic erv, eov, eun, v, pe, acc;
        rst = 1'b1;
        step(0, 0, 0);
        step(0, 0, 0);
        chk_state("reset", 0, 0, 0, 0, 0);
        chk("reset.rd_stamp", rd_stamp, 0);
        rst = 1'b0;
        add(1, 1000, 0, 1, 0, 0, 0, 0);
        add(1, 500, 0, 2, 0, 0, 0, 0);
        add(1, 7, 0, 3, 0, 0, 0, 0);
        add(0, 0, POP, 2, 1000, 1, 0, 0);
        add(0, 0, 0, 2, 1000, 1, 0, 0);
        add(0, 0, POP, 1, 500, 1, 0, 0);
        add(0, 0, 0, 1, 500, 1, 0, 0);
        add(0, 0, POP, 0, 7, 1, 0, 0);
        add(0, 0, 0, 0, 7, 1, 0, 0);
        add(1, 11, 0, 1, 7, 1, 0, 0);
        add(1, 12, 0, 2, 7, 1, 0, 0);
        add(1, 13, 0, 3, 7, 1, 0, 0);
        add(1, 14, 0, 4, 7, 1, 0, 0);
        add(1, 15, 0, 4, 7, 1, 1, 0);
        add(0, 0, POP, 3, 11, 1, 1, 0);
        add(0, 0, 0, 3, 11, 1, 1, 0);
        add(0, 0, POP, 2, 12, 1, 1, 0);
        add(0, 0, 0, 2, 12, 1, 1, 0);
        add(0, 0, POP, 1, 13, 1, 1, 0);
        add(0, 0, 0, 1, 13, 1, 1, 0);
        add(0, 0, POP, 0, 14, 1, 1, 0);
        add(0, 0, 0, 0, 14, 1, 1, 0);
        add(1, 21, 0, 1, 14, 1, 1, 0);
        add(1, 22, 0, 2, 14, 1, 1, 0);
        run_tbl("basic");
        for (int i = 0; i < 10; i++) begin
            step(0, 0, POP);
            chk_state($sformatf("hold[%0d]", i), 1, 21, 1, 1, 0);
        end
        add(0, 0, 0, 1, 21, 1, 1, 0);
        add(0, 0, POP, 0, 22, 1, 1, 0);
        add(0, 0, 0, 0, 22, 1, 1, 0);
        add(1, 33, POP, 1, 0, 0, 1, 1);
        add(0, 0, 0, 1, 0, 0, 1, 1);
        add(0, 0, POP, 0, 33, 1, 1, 1);
        add(0, 0, CLR, 0, 0, 0, 0, 0);
        add(1, 41, 0, 1, 0, 0, 0, 0);
        add(1, 42, 0, 2, 0, 0, 0, 0);
        add(1, 43, 0, 3, 0, 0, 0, 0);
        add(1, 44, 0, 4, 0, 0, 0, 0);
        add(1, 16'hBEEF, POP, 4, 41, 1, 0, 0);
        add(0, 0, 0, 4, 41, 1, 0, 0);
        add(0, 0, POP, 3, 42, 1, 0, 0);
        add(0, 0, 0, 3, 42, 1, 0, 0);
        add(0, 0, POP, 2, 43, 1, 0, 0);
        add(0, 0, 0, 2, 43, 1, 0, 0);
        add(0, 0, POP, 1, 44, 1, 0, 0);
        add(0, 0, 0, 1, 44, 1, 0, 0);
        add(0, 0, POP, 0, 16'hBEEF, 1, 0, 0);
        add(1, 56, 0, 1, 16'hBEEF, 1, 0, 0);
        add(1, 55, CLR, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        run_tbl("clr");
        rst = 1'b1;
        step(0, 0, 0);
        rst = 1'b0;
        while (cyc < 10) step(0, 0, 0);
        step(1, 100, 0);
        while (cyc < 25) step(0, 0, 0);
        step(1, 200, 0);
        step(0, 0, POP);
        chk("stamp1.rd_data", rd_data, 100);
        chk("stamp1.rd_stamp", rd_stamp, TS ? 10 : 0);
        step(0, 0, 0);
        step(0, 0, POP);
        chk("stamp2.rd_data", rd_data, 200);
        chk("stamp2.rd_stamp", rd_stamp, TS ? 25 : 0);
        rst = 1'b1;
        step(0, 0, 0);
        rst = 1'b0;
        pcmd = 0; erd = 0; est = 0; erv = 0; eov = 0; eun = 0;
        for (int i = 0; i < 400; i++) begin
            int r;
            v = $urandom_range(0, 99) < 60;
            d = 16'($urandom);
            r = $urandom_range(0, 15);
            c = r < 6 ? POP : r == 6 ? CLR : r < 12 ? 16'h0 : 16'($urandom);
            pe = c == POP && pcmd != POP;
            if (c == CLR) begin
                qd.delete(); qs.delete();
                erd = 0; est = 0; erv = 0; eov = 0; eun = 0;
            end else begin
                acc = v && (qd.size() < DEPTH || pe);
                if (v && !acc) eov = 1;
                if (pe && qd.size() > 0) begin
                    erd = qd.pop_front(); est = qs.pop_front(); erv = 1;
                end else if (pe) begin
                    erd = 0; est = 0; erv = 0; eun = 1;
                end
                if (acc) begin
                    qd.push_back(d);
                    qs.push_back(TS ? 16'(cyc) : 16'h0);
                end
            end
            pcmd = c;
            step(v, d, c);
            chk_state($sformatf("rand[%0d]", i), qd.size(), erd, erv, eov, eun);
            chk($sformatf("rand[%0d].rd_stamp", i), rd_stamp, est);
        end
        step(0, 0, 0);
        step(1, 99, 0);
        rst = 1'b1;
        step(1, 98, 0);
        chk_state("midrst", 0, 0, 0, 0, 0);
        chk("midrst.rd_stamp", rd_stamp, 0);
        rst = 1'b0;
        step(0, 0, POP);
        chk_state("postrst", 0, 0, 0, 0, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
